// File: rtl/pipeline_dump_sequencer.sv
// Streams one captured pipeline snapshot to the UART TX path as a framed dump:
// HEADER, snapshot bytes MS first, then the XOR checksum of the snapshot bytes.
module pipeline_dump_sequencer #(
  parameter int unsigned         NB_DATA     = 8,
  parameter int unsigned         NB_SNAPSHOT = 288,
  parameter logic [NB_DATA-1:0]  HEADER      = 8'hA5,
  parameter int unsigned         TIMEOUT     = 65535
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_dump_req,
  input  logic [NB_SNAPSHOT-1:0] i_snapshot,
  input  logic                   i_txDone,
  output logic                   o_tx_start,
  output logic [NB_DATA-1:0]     o_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error
);

  localparam int unsigned NBYTES = NB_SNAPSHOT / NB_DATA;
  localparam int unsigned IDX_W  = $clog2(NBYTES + 2);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT_TX = 3'd2,
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  state_t                 state_q;
  logic [NB_SNAPSHOT-1:0] shadow_q;
  logic [IDX_W-1:0]       idx_q;
  logic [NB_DATA-1:0]     csum_q;
  logic [CNT_W-1:0]       cnt_q;

  logic                   is_payload;

  // The shadow register shifts left on every acked payload byte, so the
  // byte on the wire is always its top slice.
  assign is_payload = (idx_q != '0) && (idx_q != LAST_IDX);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      csum_q   <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_dump_req) begin
            shadow_q <= i_snapshot;
            idx_q    <= '0;
            csum_q   <= '0;
            state_q  <= S_SEND;
          end
        end

        S_SEND: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_TX;
        end

        S_WAIT_TX: begin
          if (i_txDone) begin
            if (is_payload) begin
              csum_q   <= csum_q ^ shadow_q[NB_SNAPSHOT-1 -: NB_DATA];
              shadow_q <= shadow_q << NB_DATA;
            end
            if (idx_q == LAST_IDX) begin
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= S_SEND;
            end
          end else begin
            // An ack on the trip cycle is taken above, so it beats the timeout.
            if (cnt_q != CNT_MAX) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
            if (cnt_q >= CNT_TRIP) begin
              state_q <= S_ERROR;
            end
          end
        end

        S_DONE:  state_q <= S_IDLE;
        S_ERROR: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_tx_start = (state_q == S_SEND);
  assign o_done     = (state_q == S_DONE);
  assign o_error    = (state_q == S_ERROR);
  assign o_busy     = (state_q != S_IDLE);

  always_comb begin
    o_data = '0;
    if (state_q == S_SEND || state_q == S_WAIT_TX) begin
      if (idx_q == '0) begin
        o_data = HEADER;
      end else if (idx_q == LAST_IDX) begin
        o_data = csum_q;
      end else begin
        o_data = shadow_q[NB_SNAPSHOT-1 -: NB_DATA];
      end
    end
  end

endmodule

// File: tb/tb_pipeline_dump_sequencer.sv
// Drives dump frames against a byte-list reference model and a simple UART ack
// responder; covers snapshot capture, repeated requests, timeout, reset and races.
module tb_pipeline_dump_sequencer;

  localparam int NB_DATA = 8;
  localparam int NB_SNAP = 288;
  localparam int TIMEOUT = 100;
  localparam int NBYTES  = NB_SNAP / NB_DATA;
  localparam int FLEN    = NBYTES + 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req;
  logic               txdone;
  logic [NB_SNAP-1:0] snap;
  logic               o_tx_start;
  logic [7:0]         o_data;
  logic               o_busy;
  logic               o_done;
  logic               o_error;

  int n_checks = 0;
  int n_errors = 0;
  int mon_starts = 0;
  int mon_dones  = 0;
  int mon_errs   = 0;

  logic [7:0] exp_bytes [FLEN];

  always #5 clk = ~clk;

  pipeline_dump_sequencer #(
    .NB_DATA    (NB_DATA),
    .NB_SNAPSHOT(NB_SNAP),
    .HEADER     (8'hA5),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .i_rst_n   (rst_n),
    .i_dump_req(req),
    .i_snapshot(snap),
    .i_txDone  (txdone),
    .o_tx_start(o_tx_start),
    .o_data    (o_data),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_error   (o_error)
  );

  always @(negedge clk) begin
    if (o_tx_start) mon_starts <= mon_starts + 1;
    if (o_done)     mon_dones  <= mon_dones + 1;
    if (o_error)    mon_errs   <= mon_errs + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: header, snapshot bytes MS first, XOR of the snapshot bytes.
  task automatic build_frame(input logic [NB_SNAP-1:0] s);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    exp_bytes[0] = 8'hA5;
    for (int k = 0; k < NBYTES; k++) begin
      b = s[NB_SNAP-1-8*k -: 8];
      exp_bytes[k+1] = b;
      cs = cs ^ b;
    end
    exp_bytes[FLEN-1] = cs;
  endtask

  // Knobs: index of byte to withhold the ack on, to re-request during,
  // to reset during, and to ack exactly on the timeout cycle (-1 = none).
  task automatic run_frame(input logic [NB_SNAP-1:0] s, input int fixed_delay,
                           input int withhold_b, input int dupreq_b,
                           input int rst_b, input int coincide_b);
    int s0, d0, e0, d, w;
    build_frame(s);
    s0 = mon_starts;
    d0 = mon_dones;
    e0 = mon_errs;
    snap = s;
    req  = 1'b1;
    tick();
    req  = 1'b0;
    snap = {9{$urandom}};
    for (int b = 0; b < FLEN; b++) begin
      w = 0;
      while (!o_tx_start && w < 4) begin
        tick();
        w++;
      end
      check_eq($sformatf("start_latency_b%0d", b), 64'(w), 64'd0);
      if (!o_tx_start) return;
      check_eq($sformatf("byte%0d", b), {56'd0, o_data}, {56'd0, exp_bytes[b]});
      check_eq("busy_send", {63'd0, o_busy}, 64'd1);
      if (b == rst_b) begin
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1 check_eq("reset_outputs", {52'd0, o_tx_start, o_data, o_busy, o_done, o_error}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("idle_after_reset", {62'd0, o_busy, o_tx_start}, 64'd0);
        check_eq("starts_before_reset", 64'(mon_starts - s0), 64'(b + 1));
        return;
      end
      if (b == withhold_b) begin
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
          tick();
          if (k == TIMEOUT) check_eq("no_error_early", {63'd0, o_error}, 64'd0);
        end
        check_eq("error_pulse", {61'd0, o_error, o_busy, o_tx_start}, 64'b110);
        tick();
        check_eq("error_clears", {62'd0, o_error, o_busy}, 64'd0);
        for (int k = 0; k < 10; k++) tick();
        check_eq("starts_after_timeout", 64'(mon_starts - s0), 64'(b + 1));
        check_eq("error_count", 64'(mon_errs - e0), 64'd1);
        check_eq("no_done_on_timeout", 64'(mon_dones - d0), 64'd0);
        return;
      end
      if (b == coincide_b) d = TIMEOUT;
      else if (fixed_delay > 0) d = fixed_delay;
      else d = $urandom_range(1, 30);
      for (int k = 0; k < d; k++) begin
        if (k == 0 && b == dupreq_b) req = 1'b1;
        tick();
        req = 1'b0;
        check_eq("hold", {53'd0, o_tx_start, o_error, o_done, o_data},
                 {53'd0, 3'b000, exp_bytes[b]});
      end
      txdone = 1'b1;
      tick();
      txdone = 1'b0;
    end
    check_eq("done_pulse", {62'd0, o_done, o_busy}, 64'b11);
    tick();
    check_eq("done_clears", {62'd0, o_done, o_busy}, 64'd0);
    for (int k = 0; k < 30; k++) tick();
    check_eq("frame_starts", 64'(mon_starts - s0), 64'(FLEN));
    check_eq("frame_dones", 64'(mon_dones - d0), 64'd1);
    check_eq("frame_errors", 64'(mon_errs - e0), 64'd0);
  endtask

  function automatic logic [NB_SNAP-1:0] rand_snap();
    return {9{$urandom}} ^ {$urandom, $urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [NB_SNAP-1:0] seq;
    rst_n  = 1'b0;
    req    = 1'b0;
    txdone = 1'b0;
    snap   = '0;
    tick();
    tick();
    check_eq("reset_state", {52'd0, o_tx_start, o_data, o_busy, o_done, o_error}, 64'd0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_after_release", {62'd0, o_busy, o_tx_start}, 64'd0);

    for (int k = 0; k < NBYTES; k++) seq[NB_SNAP-1-8*k -: 8] = 8'(k + 1);
    run_frame(seq, 20, -1, -1, -1, -1);
    run_frame(rand_snap(), 0, -1, 5, -1, -1);
    run_frame(rand_snap(), 0, 3, -1, -1, -1);
    run_frame(rand_snap(), 0, -1, -1, -1, -1);
    run_frame(rand_snap(), 0, -1, -1, 10, -1);
    run_frame(rand_snap(), 0, -1, -1, -1, -1);

    for (int k = 0; k < 5; k++) begin
      txdone = 1'b1;
      tick();
      txdone = 1'b0;
      tick();
      check_eq("spurious_txdone_idle", {62'd0, o_tx_start, o_busy}, 64'd0);
    end
    run_frame(rand_snap(), 0, -1, -1, -1, -1);
    run_frame(rand_snap(), 0, -1, -1, -1, 2);
    for (int f = 0; f < 3; f++) run_frame(rand_snap(), 0, -1, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
